// File: rtl/ps2_host_tx_if.sv
// Host-side command port and PS/2 open-collector line controls for ps2_host_tx.
interface ps2_host_tx_if;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output ps2_clk_in, ps2_data_in, tx_data, tx_start,
      input  ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err
   );

   modport slave (
      input  ps2_clk_in, ps2_data_in, tx_data, tx_start,
      output ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, then device ACK and bus release.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  bus
);

   localparam int unsigned MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned BIT_W   = 4;

   typedef enum logic [3:0] {
      IDLE, INHIBIT, REQ, BITS, STOP, ACK_WAIT, REL_WAIT, DONE, ERR
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]         data_q, data_d;
   logic               parity_q, parity_d;
   logic               clk_oe_q, clk_oe_d;
   logic               data_oe_q, data_oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               clk_s1_q, clk_s2_q, clk_prev_q;
   logic               dat_s1_q, dat_s2_q;
   logic               fe_c;
   logic               timeout_c;

   // Line synchronisers; reset to the idle-high bus level so no edge appears after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= bus.ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= bus.ps2_data_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fe_c      = clk_prev_q & ~clk_s2_q;
   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         parity_q  <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next state; line drives are computed from the next state so the outputs stay registered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      parity_d  = parity_q;
      data_oe_d = data_oe_q;

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (bus.tx_start) begin
               data_d   = bus.tx_data;
               parity_d = ~^bus.tx_data;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            data_oe_d = 1'b0;
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REQ: begin
            data_oe_d = 1'b1;
            cnt_d     = '0;
            state_d   = BITS;
         end
         BITS: begin
            if (fe_c) begin
               cnt_d = '0;
               if (bit_cnt_q == BIT_W'(8)) begin
                  data_oe_d = ~parity_q;
                  state_d   = STOP;
               end else begin
                  data_oe_d = ~data_q[bit_cnt_q[2:0]];
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else if (timeout_c) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (fe_c) begin
               cnt_d     = '0;
               data_oe_d = 1'b0;
               state_d   = ACK_WAIT;
            end else if (timeout_c) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACK_WAIT: begin
            if (fe_c) begin
               cnt_d   = '0;
               state_d = dat_s2_q ? ERR : REL_WAIT;
            end else if (timeout_c) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REL_WAIT: begin
            if (clk_s2_q && dat_s2_q) begin
               state_d = DONE;
            end else if (timeout_c) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == IDLE || state_d == DONE || state_d == ERR) begin
         data_oe_d = 1'b0;
      end
      clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
      busy_d   = !(state_d == IDLE || state_d == DONE || state_d == ERR);
      done_d   = (state_d == DONE);
      err_d    = (state_d == ERR);
   end

   assign bus.ps2_clk_oe  = clk_oe_q;
   assign bus.ps2_data_oe = data_oe_q;
   assign bus.busy        = busy_q;
   assign bus.tx_done     = done_q;
   assign bus.tx_err      = err_q;

endmodule
